// File: rtl/triangle_rasterizer.sv
// triangle_rasterizer: scans one triangle's clipped bounding box, emitting covered pixels in raster order.
// Define RASTER_PIX_COUNT_EN to add a pix_count output counting accepted pixels per triangle.
module triangle_rasterizer #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tri_valid,
   output logic        tri_ready,
   input  logic [95:0] tri_in,
   input  logic [23:0] color_in,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [15:0] pix_x,
   output logic [15:0] pix_y,
   output logic [23:0] pix_color,
   output logic        busy,
`ifdef RASTER_PIX_COUNT_EN
   output logic        done,
   output logic [19:0] pix_count
`else
   output logic        done
`endif
);
   localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, SCAN = 2'd2, DONE = 2'd3;
   localparam logic signed [16:0] XL = 17'(WIDTH - 1);
   localparam logic signed [16:0] YL = 17'(HEIGHT - 1);

   logic [1:0]  state;
   logic [95:0] tri_q;
   logic [23:0] color_q;
   logic [15:0] xmin, xmax, ymin, ymax, cur_x, cur_y;
   logic signed [16:0] px, py, qx, qy, rx, ry, cx, cy;
   logic signed [16:0] x_lo, x_hi, y_lo, y_hi;
   logic signed [35:0] e_pq, e_qr, e_rp, area;
   logic cov, empty, adv;

   // Vertices sign-extended to 17 bits so every difference fits without overflow
   assign px = {tri_q[95], tri_q[95:80]};
   assign py = {tri_q[79], tri_q[79:64]};
   assign qx = {tri_q[63], tri_q[63:48]};
   assign qy = {tri_q[47], tri_q[47:32]};
   assign rx = {tri_q[31], tri_q[31:16]};
   assign ry = {tri_q[15], tri_q[15:0]};
   assign cx = {1'b0, cur_x};
   assign cy = {1'b0, cur_y};

   function automatic logic signed [35:0] edge_fn(input logic signed [16:0] ax, ay, bx, by, x, y);
      logic signed [16:0] dxb, dyb, dxp, dyp;
      dxb = bx - ax;
      dyb = by - ay;
      dxp = x - ax;
      dyp = y - ay;
      return 36'(dxb) * 36'(dyp) - 36'(dyb) * 36'(dxp);
   endfunction

   function automatic logic signed [16:0] min3(input logic signed [16:0] a, b, c);
      logic signed [16:0] m;
      m = a < b ? a : b;
      return m < c ? m : c;
   endfunction

   function automatic logic signed [16:0] max3(input logic signed [16:0] a, b, c);
      logic signed [16:0] m;
      m = a > b ? a : b;
      return m > c ? m : c;
   endfunction

   always_comb begin
      x_lo  = min3(px, qx, rx);
      x_hi  = max3(px, qx, rx);
      y_lo  = min3(py, qy, ry);
      y_hi  = max3(py, qy, ry);
      x_lo  = x_lo < 17'sd0 ? 17'sd0 : x_lo;
      x_hi  = x_hi > XL ? XL : x_hi;
      y_lo  = y_lo < 17'sd0 ? 17'sd0 : y_lo;
      y_hi  = y_hi > YL ? YL : y_hi;
      area  = edge_fn(px, py, qx, qy, rx, ry);
      empty = (x_lo > x_hi) || (y_lo > y_hi) || (area == 36'sd0);
      e_pq  = edge_fn(px, py, qx, qy, cx, cy);
      e_qr  = edge_fn(qx, qy, rx, ry, cx, cy);
      e_rp  = edge_fn(rx, ry, px, py, cx, cy);
      cov   = (e_pq >= 0 && e_qr >= 0 && e_rp >= 0) || (e_pq <= 0 && e_qr <= 0 && e_rp <= 0);
      adv   = !cov || pix_ready;
   end

   assign tri_ready = (state == IDLE) && !rst;
   assign busy      = state != IDLE;
   assign done      = state == DONE;
   assign pix_valid = (state == SCAN) && cov;
   assign pix_x     = cur_x;
   assign pix_y     = cur_y;
   assign pix_color = color_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         tri_q   <= '0;
         color_q <= '0;
         xmin    <= '0;
         xmax    <= '0;
         ymin    <= '0;
         ymax    <= '0;
         cur_x   <= '0;
         cur_y   <= '0;
      end else begin
         case (state)
            IDLE: if (tri_valid) begin
               tri_q   <= tri_in;
               color_q <= color_in;
               state   <= SETUP;
            end
            SETUP: begin
               xmin  <= x_lo[15:0];
               xmax  <= x_hi[15:0];
               ymin  <= y_lo[15:0];
               ymax  <= y_hi[15:0];
               cur_x <= x_lo[15:0];
               cur_y <= y_lo[15:0];
               state <= empty ? DONE : SCAN;
            end
            SCAN: if (adv) begin
               cur_x <= cur_x == xmax ? xmin : cur_x + 16'd1;
               cur_y <= cur_x == xmax ? cur_y + 16'd1 : cur_y;
               state <= (cur_x == xmax && cur_y == ymax) ? DONE : SCAN;
            end
            default: state <= IDLE;
         endcase
      end

`ifdef RASTER_PIX_COUNT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) pix_count <= '0;
      else if (tri_valid && tri_ready) pix_count <= '0;
      else if (pix_valid && pix_ready) pix_count <= pix_count + 20'd1;
`endif
endmodule

// File: tb/tb_triangle_rasterizer.sv
// tb_triangle_rasterizer: directed vectors for triangle_rasterizer with hand-derived pixel lists.
module tb_triangle_rasterizer;
   logic        clk = 1'b0;
   logic        rst;
   logic        tri_valid;
   logic        tri_ready;
   logic [95:0] tri_in;
   logic [23:0] color_in;
   logic        pix_valid;
   logic        pix_ready;
   logic [15:0] pix_x, pix_y;
   logic [23:0] pix_color;
   logic        busy, done;
`ifdef RASTER_PIX_COUNT_EN
   logic [19:0] pix_count;
`endif

   int n_vec = 0, n_err = 0, ndone, lat;
   int gx[$], gy[$], gc[$], ex[$], ey[$];

   triangle_rasterizer dut (
      .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
      .tri_in(tri_in), .color_in(color_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .busy(busy),
`ifdef RASTER_PIX_COUNT_EN
      .done(done), .pix_count(pix_count)
`else
      .done(done)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [95:0] mk(input int ax, ay, bx, by, cx, cy);
      return {16'(ax), 16'(ay), 16'(bx), 16'(by), 16'(cx), 16'(cy)};
   endfunction

   task automatic send(input logic [95:0] t, input logic [23:0] c);
      @(negedge clk);
      tri_valid = 1'b1;
      tri_in    = t;
      color_in  = c;
      chk("tri_ready_at_offer", 32'(tri_ready), 32'd1);
      @(posedge clk);
      #1 tri_valid = 1'b0;
   endtask

   // Samples from the current negedge onward until done or the cycle budget runs out
   task automatic collect();
      gx.delete();
      gy.delete();
      gc.delete();
      ndone = 0;
      lat   = 0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         if (pix_valid && pix_ready) begin
            gx.push_back(int'(pix_x));
            gy.push_back(int'(pix_y));
            gc.push_back(int'(pix_color));
         end
         if (done) begin
            ndone = 1;
            lat   = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_list(input string tag, input logic [23:0] c);
      chk({tag, "_done_seen"}, 32'(ndone), 32'd1);
      chk({tag, "_npix"}, 32'(gx.size()), 32'(ex.size()));
      for (int i = 0; i < gx.size() && i < ex.size(); i++) begin
         chk($sformatf("%s_x%0d", tag, i), 32'(gx[i]), 32'(ex[i]));
         chk($sformatf("%s_y%0d", tag, i), 32'(gy[i]), 32'(ey[i]));
         chk($sformatf("%s_c%0d", tag, i), 32'(gc[i]), 32'(c));
      end
`ifdef RASTER_PIX_COUNT_EN
      chk({tag, "_pix_count"}, 32'(pix_count), 32'(ex.size()));
`endif
      @(negedge clk);
      chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
      chk({tag, "_ready_after_done"}, 32'(tri_ready), 32'd1);
   endtask

   task automatic run_full(input logic [95:0] t, input logic [23:0] c, input string tag);
      send(t, c);
      @(negedge clk);
      collect();
      check_list(tag, c);
   endtask

   // Right triangle with legs of 3: covered points satisfy x+y<=3
   task automatic expect_t1();
      ex.delete();
      ey.delete();
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++)
            if (x + y <= 3) begin
               ex.push_back(x);
               ey.push_back(y);
            end
   endtask

   initial begin
      rst       = 1'b1;
      tri_valid = 1'b0;
      tri_in    = '0;
      color_in  = '0;
      pix_ready = 1'b1;
      #1;
      chk("rst_tri_ready", 32'(tri_ready), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pix_x", 32'(pix_x), 32'd0);
      chk("rst_pix_y", 32'(pix_y), 32'd0);
      chk("rst_pix_color", 32'(pix_color), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("ready_after_rst", 32'(tri_ready), 32'd1);

      expect_t1();
      run_full(mk(0, 0, 3, 0, 0, 3), 24'hFF0000, "ccw");

      send(mk(0, 0, 2, 2, 4, 4), 24'h00FF00);
      @(negedge clk);
      collect();
      chk("degen_done_seen", 32'(ndone), 32'd1);
      chk("degen_npix", 32'(gx.size()), 32'd0);
      chk("degen_done_latency", 32'(lat), 32'd2);

      ex.delete();
      ey.delete();
      ex.push_back(0);
      ey.push_back(0);
      run_full(mk(-4, -4, 4, -4, -4, 4), 24'h0000FF, "clip");

      pix_ready = 1'b0;
      send(mk(0, 0, 3, 0, 0, 3), 24'hFF0000);
      for (int i = 0; i < 10 && !pix_valid; i++) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("stall_valid%0d", k), 32'(pix_valid), 32'd1);
         chk($sformatf("stall_x%0d", k), 32'(pix_x), 32'd0);
         chk($sformatf("stall_y%0d", k), 32'(pix_y), 32'd0);
         chk($sformatf("stall_ready%0d", k), 32'(tri_ready), 32'd0);
      end
      pix_ready = 1'b1;
      expect_t1();
      collect();
      check_list("stall", 24'hFF0000);

      send(mk(0, 0, 3, 0, 0, 3), 24'h123456);
      repeat (3) @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_pix_valid", 32'(pix_valid), 32'd1);
      chk("mid_pix_x", 32'(pix_x), 32'd1);
      rst = 1'b1;
      #1;
      chk("mrst_pix_valid", 32'(pix_valid), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_tri_ready", 32'(tri_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("mrst_ready_after", 32'(tri_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("mrst_no_done%0d", k), 32'(done), 32'd0);
      end

      expect_t1();
      run_full(mk(0, 0, 0, 3, 3, 0), 24'hABCDEF, "cw");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/triangle_rasterizer.md
TRIANGLE_RASTERIZER -- requirements
Module: triangle_rasterizer

Interface
REQ-001 Parameter WIDTH, default 640: screen width in pixels.
REQ-002 Parameter HEIGHT, default 480: screen height in pixels.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tri_valid  input  1  triangle offered.
REQ-006 tri_ready  output  1  block accepts triangle this cycle.
REQ-007 tri_in  input  96  Triangle2D {p,q,r}; each Point2D {x,y} as signed 16-bit.
REQ-008 color_in  input  24  Color {r,g,b}; sampled with tri_in.
REQ-009 pix_valid  output  1  pix_x/pix_y/pix_color hold a covered pixel.
REQ-010 pix_ready  input  1  downstream accepts pixel.
REQ-011 pix_x, pix_y  output  16 each  pixel coordinates, unsigned, in screen range.
REQ-012 pix_color  output  24  latched triangle color.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse when the triangle is finished.

Function
REQ-015 FSM states: IDLE, SETUP, SCAN, DONE.
REQ-016 tri_ready = (state==IDLE); transfer when tri_valid && tri_ready; tri_in and color_in latched, next state SETUP.
REQ-017 SETUP (1 cycle): bbox xmin/xmax/ymin/ymax = min3/max3 of vertex coordinates, clipped to [0,WIDTH-1] x [0,HEIGHT-1]; twice-area computed.
REQ-018 SETUP -> DONE if clipped bbox is empty (min>max on either axis) or twice-area == 0 (degenerate); otherwise -> SCAN with cur_x=xmin, cur_y=ymin.
REQ-019 Edge functions E_ab(x,y) = (bx-ax)*(y-ay) - (by-ay)*(x-ax) for edges pq, qr, rp; 17-bit signed differences, 36-bit signed products and sums, no overflow.
REQ-020 Covered iff all three E >= 0 or all three E <= 0 (either winding; edges and vertices inclusive).
REQ-021 SCAN: pix_valid = covered(cur_x,cur_y); pix_x=cur_x, pix_y=cur_y, pix_color=latched color.
REQ-022 Candidate advances when !covered or (pix_valid && pix_ready); otherwise position and all pix outputs held stable.
REQ-023 Raster order: x increments to xmax, then x=xmin and y increments; advance from (xmax,ymax) -> DONE.
REQ-024 One candidate per cycle; first pix_valid no earlier than 2 cycles after the accepting edge.
REQ-025 DONE (1 cycle): done=1, -> IDLE; tri_ready high the following cycle.
REQ-026 pix_valid is 0 in IDLE, SETUP, DONE; never deasserted while pix_ready is low.

Reset
REQ-027 rst asserted: immediately state=IDLE, pix_valid=0, done=0, busy=0, tri_ready=0, pix_x=pix_y=0, pix_color=0, all counters and latches 0.
REQ-028 rst mid-triangle discards the triangle with no done pulse; tri_ready=1 first cycle after deassertion.

Configuration
REQ-029 Macro RASTER_PIX_COUNT_EN defined: extra output pix_count (20 bits) counts pixel transfers of the current triangle, cleared on triangle accept, holds final value from done until next accept; reset 0.
REQ-030 Macro undefined: pix_count port and counter absent; all other behaviour identical.

Verification
REQ-031 Tri (0,0),(3,0),(0,3), color 0xFF0000, pix_ready=1 -> 10 pixels in order (0..3,0),(0..2,1),(0..1,2),(0,3), all 0xFF0000, then one done pulse; pix_count=10 if enabled.
REQ-032 Same tri reverse winding (0,0),(0,3),(3,0) -> identical 10 pixels and order.
REQ-033 Degenerate (0,0),(2,2),(4,4) -> zero pix_valid, done 2 cycles after accepting edge.
REQ-034 Tri (-4,-4),(4,-4),(-4,4) -> bbox clipped to 0..4, exactly one pixel (0,0) emitted.
REQ-035 REQ-031 stimulus with pix_ready=0 for 5 cycles at first pixel -> pix_valid=1, pix (0,0) stable all 5 cycles, tri_ready=0; sequence then completes unchanged.
REQ-036 rst pulsed while in SCAN -> pix_valid=0 immediately, no done, tri_ready=1 first cycle after release; next triangle rasterizes correctly.
